// File: rtl/ara_pkg.sv
// Shared types for the Ara D-cache invalidation sequencer.
// Holds the sequencer FSM encoding and the line-offset mask helpers.
package ara_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        ACK
    } inval_seq_state_e;

    localparam int unsigned InvalL1LineWidth = 16;
    localparam logic [63:0] InvalLineOffMask = 64'(InvalL1LineWidth - 1);

    // Byte-offset mask within one L1 line (line width is a power of two)
    function automatic logic [63:0] line_off_mask(input int unsigned lw);
        return 64'(lw - 1);
    endfunction

endpackage

// File: rtl/ara_inval_rr_arbiter.sv
// Round-robin grant over NrSrc requesters.
// The search starts at the pointer; the pointer moves past the winner on accept.
module ara_inval_rr_arbiter #(
    parameter int unsigned NrSrc = 2,
    parameter int unsigned IdxW  = (NrSrc > 1) ? $clog2(NrSrc) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrSrc-1:0] req_i,
    input  logic             accept_i,
    output logic [NrSrc-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = ptr_q;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < NrSrc; k++) begin
            j = (32'(ptr_q) + k) % NrSrc;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                idx_o    = IdxW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (32'(idx_o) == NrSrc - 1) ? '0 : idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ara_inval_sequencer.sv
// Expands address-range requests into per-line D-cache invalidations
// onto CVA6's single inval port, with repeat-line suppression.
module ara_inval_sequencer
    import ara_pkg::*;
#(
    parameter int unsigned NrSrc         = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned L1LineWidth   = 16,
    parameter int unsigned MaxLinesWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [NrSrc-1:0]               req_valid_i,
    output logic [NrSrc-1:0]               req_ready_o,
    input  logic [NrSrc*AddrWidth-1:0]     req_addr_i,
    input  logic [NrSrc*MaxLinesWidth-1:0] req_nlines_i,
    output logic [NrSrc-1:0]               ack_o,
    output logic                           inval_valid_o,
    output logic [AddrWidth-1:0]           inval_addr_o,
    input  logic                           inval_ready_i,
    output logic                           busy_o
);

    localparam int unsigned IdxW = (NrSrc > 1) ? $clog2(NrSrc) : 1;
    localparam logic [AddrWidth-1:0] OffMask =
        AddrWidth'(line_off_mask(L1LineWidth));
    localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);
    localparam logic [MaxLinesWidth-1:0] One = MaxLinesWidth'(1);

    inval_seq_state_e state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [AddrWidth-1:0] cur_q, cur_d;
    logic [AddrWidth-1:0] last_q, last_d;
    logic last_valid_q, last_valid_d;
    logic [MaxLinesWidth-1:0] rem_q, rem_d;

    logic [NrSrc-1:0] gnt;
    logic [IdxW-1:0] gnt_idx;
    logic gnt_valid;
    logic idle;
    logic accept;
    logic skip;
    logic [AddrWidth-1:0] sel_addr;
    logic [MaxLinesWidth-1:0] sel_nlines;

    assign idle   = (state_q == IDLE);
    assign accept = idle && gnt_valid;
    assign skip   = last_valid_q && (cur_q == last_q);

    ara_inval_rr_arbiter #(
        .NrSrc (NrSrc),
        .IdxW  (IdxW)
    ) i_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx),
        .valid_o  (gnt_valid)
    );

    always_comb begin
        int unsigned sel;
        sel        = 32'(gnt_idx);
        sel_addr   = req_addr_i[sel*AddrWidth +: AddrWidth];
        sel_nlines = req_nlines_i[sel*MaxLinesWidth +: MaxLinesWidth];
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cur_d        = cur_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        rem_d        = rem_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = gnt_idx;
                    cur_d   = sel_addr & ~OffMask;
                    rem_d   = sel_nlines;
                    if (en_i && (sel_nlines != '0)) begin
                        state_d = EMIT;
                    end else begin
                        state_d = ACK;
                        if (!en_i) last_valid_d = 1'b0;
                    end
                end
            end
            EMIT: begin
                // A suppressed repeat line still consumes a slot
                if (skip || inval_ready_i) begin
                    cur_d = cur_q + LineStep;
                    rem_d = rem_q - One;
                    if (!skip) begin
                        last_d       = cur_q;
                        last_valid_d = 1'b1;
                    end
                    if (rem_q == One) state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_o = '0;
        for (int unsigned i = 0; i < NrSrc; i++) begin
            ack_o[i] = (state_q == ACK) && (32'(grant_q) == i);
        end
    end

    assign req_ready_o   = idle ? gnt : '0;
    assign inval_valid_o = (state_q == EMIT) && !skip;
    assign inval_addr_o  = (state_q == EMIT) ? cur_q : '0;
    assign busy_o        = !idle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            cur_q        <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            rem_q        <= rem_d;
        end
    end

endmodule

// File: doc/ara_inval_sequencer.md
# ara_inval_sequencer

Sequences D-cache line invalidations from several address-range requesters onto CVA6's single inval_valid/inval_ready port in the Ara system. Requests are shared through a round-robin arbiter. Each accepted range is expanded into one invalidation per L1 line, with the previously emitted line suppressed if repeated. Each requester gets a one-cycle completion pulse. The block sits between the vector store path / DMA-style producers and the acc_resp invalidation fields packed for CVA6.

## Interface
- NrSrc, 2: number of requesters (≥1).
- AddrWidth, 64: address width in bits.
- L1LineWidth, 16: D-cache line size in bytes (power of two).
- MaxLinesWidth, 8: width of the per-request line count.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  invalidation enable; sampled at request accept.
- req_valid_i  in  NrSrc  per-source request valid.
- req_ready_o  out  NrSrc  per-source accept; at most one bit high.
- req_addr_i  in  NrSrc×AddrWidth  per-source start byte address.
- req_nlines_i  in  NrSrc×MaxLinesWidth  per-source number of lines; 0 is legal.
- ack_o  out  NrSrc  one-cycle completion pulse to the granted source.
- inval_valid_o  out  1  invalidation valid toward CVA6.
- inval_addr_o  out  AddrWidth  line-aligned invalidation address.
- inval_ready_i  in  1  CVA6 accepts the invalidation.
- busy_o  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE → EMIT on accept when the sampled en_i=1 and nlines≠0.
  - IDLE → ACK on accept when en_i=0 or nlines=0.
  - EMIT → ACK on the handshake of the last line.
  - ACK → IDLE unconditionally.
- Arbitration is round-robin. Pointer resets to 0; the search starts at the pointer. After a grant to i, pointer = (i+1) mod NrSrc.
- req_ready_o is nonzero only in IDLE, and only for the arbitration winner among asserted req_valid_i.
- Accept latches:
  - grant index;
  - base = req_addr & ~(L1LineWidth-1);
  - remaining count = nlines;
  - sampled en_i.
- EMIT:
  - inval_addr_o = cur_line; inval_valid_o = 1.
  - On inval_ready_i: cur_line += L1LineWidth, modulo 2^AddrWidth (wrap allowed, no error); remaining -= 1.
- Dedupe: if last_valid and cur_line == last_line, the line is skipped without asserting inval_valid_o. A skip consumes one cycle and counts toward remaining.
  - last_line and last_valid update on every completed handshake.
  - last_valid clears on reset and whenever an accept samples en_i=0.
- ACK: ack_o[grant] = 1 for exactly one cycle; all other ack bits stay 0.
- en_i changing during EMIT has no effect on the request in flight.
- No new request is accepted before returning to IDLE. Requests held by other sources wait, and their valid must stay stable (AXI-style).

## Timing
- Reset values: state IDLE, rr pointer 0, last_valid 0. All outputs 0: req_ready_o, ack_o, inval_valid_o, inval_addr_o, busy_o.
- Reset mid-EMIT: next cycle all outputs 0; the pending invalidation is dropped and no ack is issued.
- Accept at cycle T:
  - first inval_valid_o at T+1;
  - with inval_ready_i tied high, one line per cycle;
  - for N emitted lines with no stalls: last handshake at T+N, ack_o at T+N+1, IDLE at T+N+2, next accept at T+N+2 at the earliest.
- Disabled or zero-line request accepted at T: ack_o at T+1, next accept at T+2.
- While inval_valid_o=1 and inval_ready_i=0, inval_addr_o is held stable and inval_valid_o is not withdrawn.
- No combinational path from inval_ready_i or req_valid_i to inval_valid_o. req_ready_o depends combinationally on req_valid_i (arbiter).

## Structure
- ara_pkg:
  - inval_seq_state_e {IDLE, EMIT, ACK};
  - localparam for the line-offset mask derived from L1LineWidth.
- Sub-module ara_inval_rr_arbiter: NrSrc-wide round-robin grant with pointer register; updates the pointer only on an accepted grant.
- Line counter, address register and dedupe register stay in the top-level.

## Test plan
- Single source, en_i=1, addr=0x1008, nlines=3, ready high → inval_addr 0x1000, 0x1010, 0x1020 on T+1..T+3; ack_o[0] at T+4.
- Backpressure: inval_ready_i low for 5 cycles on the second line → inval_addr_o held at 0x1010 with valid high; total ack delayed by 5 cycles.
- Both sources valid continuously, nlines=1 each, addresses 0x2000/0x3000 → grants alternate 0,1,0,1; acks alternate accordingly; no starvation.
- Dedupe: request 0x4000/nlines=1, then 0x4000/nlines=2 → second request emits only 0x4010; ack after 2 EMIT cycles (one skip, one handshake).
- en_i=0 or nlines=0 → no inval_valid_o; ack_o one cycle after accept. Wrap case: addr=0xFFFF_FFFF_FFFF_FFF0, nlines=2 → 0x…FFF0 then 0x0.
- Assert rst_i during EMIT with ready low → all outputs 0 next cycle; a fresh request afterwards starts arbitration at source 0.
